// File: rtl/des_round_ctrl_if.sv
// Handshake and data bundle between a DES datapath sequencer and the
// round controller: start/mode/key requests in, L/R strobes and subkey out.
interface des_round_ctrl_if;
    logic        start;
    logic        decrypt;
    logic [55:0] key_cd;
    logic        abort;
    logic        load_init;
    logic        en;
    logic [3:0]  rnd;
    logic [47:0] subkey;
    logic        busy;
    logic        done;

    modport master (
        output start, decrypt, key_cd, abort,
        input  load_init, en, rnd, subkey, busy, done
    );

    modport slave (
        input  start, decrypt, key_cd, abort,
        output load_init, en, rnd, subkey, busy, done
    );
endinterface

// File: rtl/des_round_ctrl.sv
// DES round controller: sequences the 16 Feistel rounds, keeps the rotating
// C/D key register and presents the PC-2 subkey for the current round.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; CD keeps whatever the last run left there
// S_LOAD  | L/R registers take the initial permutation (load_init high)
// S_ROUND | one Feistel round per cycle, rnd = 0..15, subkey valid
// S_DONE  | one-cycle completion pulse, then back to idle
module des_round_ctrl #(
    parameter int ROUNDS = 16
) (
    input  logic            clk,
    input  logic            rst,
    des_round_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

    // PC-2 selection, FIPS 46-3 numbering: bit 1 is the MSB of {C,D}.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_q, state_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [55:0] cd_q, cd_d;
    logic        mode_q, mode_d;
    logic [47:0] subkey_w;

    // Shift schedule: rounds 0, 1, 8 and 15 rotate by one, the rest by two.
    function automatic logic shift_two(input logic [3:0] idx);
        return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
    endfunction

    function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic two);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (two) begin
            c = {c[25:0], c[27:26]};
            d = {d[25:0], d[27:26]};
        end else begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic two);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (two) begin
            c = {c[1:0], c[27:2]};
            d = {d[1:0], d[27:2]};
        end else begin
            c = {c[0], c[27:1]};
            d = {d[0], d[27:1]};
        end
        return {c, d};
    endfunction

    // State, round counter, key register and mode flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rnd_q   <= 4'd0;
            cd_q    <= 56'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            cd_q    <= cd_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and key-schedule stepping; abort outranks round advance.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        cd_d    = cd_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    mode_d  = bus.decrypt;
                    // Encrypt starts from C1D1; decrypt from C0D0, which equals C16D16.
                    cd_d    = bus.decrypt ? bus.key_cd : rotl_cd(bus.key_cd, 1'b0);
                end
            end
            S_LOAD: begin
                rnd_d   = 4'd0;
                state_d = bus.abort ? S_IDLE : S_ROUND;
            end
            S_ROUND: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    rnd_d   = 4'd0;
                end else if (rnd_q == LAST_RND) begin
                    state_d = S_DONE;
                    rnd_d   = 4'd0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                    cd_d  = mode_q ? rotr_cd(cd_q, shift_two(4'd15 - rnd_q))
                                   : rotl_cd(cd_q, shift_two(rnd_q + 4'd1));
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rnd_d   = 4'd0;
            end
        endcase
    end

    // PC-2 compression of the current CD register.
    always_comb begin
        subkey_w = 48'd0;
        for (int i = 0; i < 48; i++) begin
            subkey_w[47 - i] = cd_q[56 - PC2[i]];
        end
    end

    // Moore outputs decoded from registered state.
    always_comb begin
        bus.load_init = (state_q == S_LOAD);
        bus.en        = (state_q == S_ROUND);
        bus.busy      = (state_q == S_LOAD) || (state_q == S_ROUND);
        bus.done      = (state_q == S_DONE);
        bus.rnd       = (state_q == S_ROUND) ? rnd_q : 4'd0;
        bus.subkey    = subkey_w;
    end

endmodule

// File: doc/des_round_ctrl.md
DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 16, number of Feistel rounds; only 16 is supported.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin one block operation; sampled only in IDLE.
REQ-005 decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with start.
REQ-006 key_cd  input  56  post-PC-1 key {C0[27:0], D0[27:0]}; sampled with start.
REQ-007 abort  input  1  synchronous cancel of the operation in progress.
REQ-008 load_init  output  1  drives the L/R registers' initial-load strobe.
REQ-009 en  output  1  drives the L/R registers' round-advance enable.
REQ-010 rnd  output  4  current round index 0..15; 0 outside ROUND.
REQ-011 subkey  output  48  PC-2 (FIPS 46-3) of the current CD register.
REQ-012 busy  output  1  high in LOAD and ROUND.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 FSM states are IDLE, LOAD, ROUND and DONE; all outputs are Moore, decoded from registered state only.
REQ-015 IDLE with start=1 at posedge -> LOAD; mode_q <= decrypt; CD <= rotl1(key_cd) halves if encrypt, key_cd unrotated if decrypt.
REQ-016 LOAD: load_init=1, en=0, busy=1; next edge -> ROUND with rnd=0.
REQ-017 ROUND: en=1, load_init=0, busy=1; each edge rnd increments; after the edge at rnd=15 -> DONE.
REQ-018 Shift table s[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, applied to C and D independently as 28-bit rotations.
REQ-019 In ROUND at rnd=r<15: encrypt CD <= rotl by s[r+1]; decrypt CD <= rotr by s[15-r]; at r=15 CD holds.
REQ-020 Result: subkey in ROUND equals K(r+1) when encrypting and K(16-r) when decrypting.
REQ-021 DONE: done=1, busy=0, en=0 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-022 Latency: start accepted at edge E0 -> load_init high E0..E1, en high E1..E17, done high E17..E18.
REQ-023 start in LOAD, ROUND or DONE is ignored; start held high through DONE re-launches only from IDLE (earliest at E18).
REQ-024 decrypt/key_cd changes after acceptance have no effect; mode_q and CD govern the operation.
REQ-025 abort=1 in LOAD or ROUND -> IDLE at next edge, rnd=0, no done pulse; abort takes priority over round advance.
REQ-026 abort in IDLE or DONE has no effect; abort and start both high in IDLE -> start wins.
REQ-027 CD register is not cleared on return to IDLE; subkey is don't-care outside ROUND.

Reset
REQ-028 rst=0 forces IDLE, rnd=0, CD=0, mode_q=0, load_init=0, en=0, busy=0, done=0 immediately, independent of clk.
REQ-029 Reset asserted mid-operation discards it with no done pulse; after rst=1, first start is accepted normally.

Verification
REQ-030 Encrypt, key_cd=56'hF0CCAAF556678F (FIPS key 133457799BBCDFF1), start 1 cycle -> load_init 1 cycle, then subkey 48'h1B02EFFC7072 at rnd=0, 48'h79AED9DBC9E5 at rnd=1, 48'hCB3D8B0E17F5 at rnd=15; done 17 cycles after acceptance.
REQ-031 Same key, decrypt=1 -> subkey 48'hCB3D8B0E17F5 at rnd=0, 48'h1B02EFFC7072 at rnd=15; en high exactly 16 cycles.
REQ-032 start toggled at rnd=5 and start held high through DONE -> no restart mid-run; second load_init begins exactly one cycle after done.
REQ-033 abort at rnd=7 -> busy=0 and rnd=0 next cycle, no done; following start produces full correct K1..K16 sequence.
REQ-034 rst=0 for 7 ns mid-ROUND (not edge-aligned) -> all outputs 0 during reset; recovery run matches REQ-030 values.
REQ-035 Change decrypt and key_cd to 0 at rnd=3 -> subkey sequence unchanged from REQ-030.
